// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb and
// polices the unified memory port. Optional perf counters: define CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TO_W        = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       br_cond,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_we,
   output logic       mdr_we,
   output logic       pc_we,
   output logic       pc_src,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic [1:0] alu_op,
   output logic       reg_we,
   output logic [1:0] wb_sel,
   output logic       halt,
   output logic [1:0] err
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0] cyc_cnt,
   output logic [31:0] ret_cnt
`endif
);

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpOpImm  = 7'b0010011;
   localparam logic [6:0] OpOp     = 7'b0110011;

   localparam bit            ToEn   = (MEM_TIMEOUT != 0);
   localparam logic [TO_W-1:0] ToLast = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExec, StMem, StWb, StTrap
   } state_e;

   state_e          state_q, state_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [1:0]      err_q, err_d;

   logic is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_opimm, is_op;
   logic legal, timed_out;

   assign is_load   = (opcode == OpLoad);
   assign is_store  = (opcode == OpStore);
   assign is_branch = (opcode == OpBranch);
   assign is_jal    = (opcode == OpJal);
   assign is_jalr   = (opcode == OpJalr);
   assign is_lui    = (opcode == OpLui);
   assign is_auipc  = (opcode == OpAuipc);
   assign is_opimm  = (opcode == OpOpImm);
   assign is_op     = (opcode == OpOp);
   assign legal = is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_auipc |
                  is_opimm | is_op;

   // A ready in the last allowed wait cycle still completes the access.
   assign timed_out = ToEn && !mem_ready && (to_q == ToLast);

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      to_d      = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      mdr_we    = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 1'b0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = 2'b00;
      reg_we    = 1'b0;
      wb_sel    = 2'b00;
      halt      = 1'b0;
      case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = StDecode;
            end else if (timed_out) begin
               state_d = StTrap;
               err_d   = 2'b10;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         StDecode: begin
            if (legal) begin
               state_d = StExec;
            end else begin
               state_d = StTrap;
               err_d   = 2'b01;
            end
         end
         StExec: begin
            if (is_load || is_store) begin
               alu_b_sel = 1'b1;
               state_d   = StMem;
            end else if (is_branch) begin
               alu_a_sel = 1'b1;
               alu_b_sel = 1'b1;
               pc_src    = 1'b1;
               pc_we     = br_cond;
               state_d   = StFetch;
            end else if (is_jal || is_jalr) begin
               alu_a_sel = is_jal;
               alu_b_sel = 1'b1;
               pc_src    = 1'b1;
               pc_we     = 1'b1;
               state_d   = StWb;
            end else if (is_op || is_opimm) begin
               alu_b_sel = is_opimm;
               alu_op    = 2'b01;
               state_d   = StWb;
            end else if (is_auipc) begin
               alu_a_sel = 1'b1;
               alu_b_sel = 1'b1;
               state_d   = StWb;
            end else if (is_lui) begin
               state_d = StWb;
            end else begin
               state_d = StTrap;
               err_d   = 2'b01;
            end
         end
         StMem: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = is_store;
            if (mem_ready) begin
               mdr_we  = is_load;
               state_d = is_load ? StWb : StFetch;
            end else if (timed_out) begin
               state_d = StTrap;
               err_d   = 2'b10;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         StWb: begin
            reg_we  = 1'b1;
            wb_sel  = is_load ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
            state_d = StFetch;
         end
         StTrap: halt = 1'b1;
         default: state_d = StIdle;
      endcase
   end

   assign err = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         to_q    <= '0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
         err_q   <= err_d;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cyc_q, cyc_d, ret_q, ret_d;
   logic        ret_fire;

   always_comb begin
      ret_fire = (state_q == StWb) || ((state_q == StExec) && is_branch) ||
                 ((state_q == StMem) && is_store && mem_ready);
      cyc_d = cyc_q;
      ret_d = ret_q;
      if (state_q != StIdle && state_q != StTrap) cyc_d = cyc_q + 32'd1;
      if (ret_fire) ret_d = ret_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ret_q <= ret_d;
      end
   end

   assign cyc_cnt = cyc_q;
   assign ret_cnt = ret_q;
`endif

endmodule
